// File: rtl/req_priority_encoder_pkg.sv
// Shared definitions for the request priority encoder: default sizes,
// output-stage state encoding and small vector helpers.
package req_enc_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Number of set bits in an N-bit vector.
  function automatic logic [IDX_W_DEF:0] popcount(input logic [N_DEF-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_DEF; i++) begin
      popcount = popcount + {{IDX_W_DEF{1'b0}}, v[i]};
    end
  endfunction

endpackage

// File: rtl/req_priority_encoder_prio_pick.sv
// Combinational find-first-set with a start pointer. The search begins at
// bit 'start' and wraps modulo N; with start tied to zero it is a plain
// lowest-index-wins priority picker.
module prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Walk the vector from the start pointer and latch the first set bit.
  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!found && vec[k]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Sequential priority encoder: request pulses collect in a sticky pending
// register and are handed out one index at a time on a valid/ready stage.
// Requests that hit an already pending bit, or the index stalled in the
// output stage, are dropped and counted.
// Build option: define REQ_PRIORITY_ENCODER_RR_EN for rotating priority
// (search starts after the last serviced index); otherwise the lowest
// pending index always wins.
module req_priority_encoder
  import req_enc_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             clr_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic [N-1:0]     pending_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  stage_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [N-1:0]     onehot_reg, onehot_next;
  logic [N-1:0]     pending_reg, pending_next;
  logic             ovf_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [N-1:0]     held_mask;
  logic [N-1:0]     drops;
  logic [N-1:0]     pend_nx;
  logic             slot_free;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] start_ptr;
  logic [CNT_W:0]   cnt_sum;

`ifdef REQ_PRIORITY_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  assign start_ptr = ptr_reg;
`else
  assign start_ptr = '0;
`endif

  // A stalled index cannot be re-requested: that pulse is lost, not queued.
  // Requests for bits already pending are likewise lost.
  always_comb begin
    held_mask = '0;
    if (state_reg == ST_FULL && !out_ready) begin
      held_mask = onehot_reg;
    end
    drops     = req_i & (pending_reg | held_mask);
    pend_nx   = pending_reg | (req_i & ~held_mask);
    slot_free = (state_reg == ST_EMPTY) || out_ready;
  end

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (pend_nx),
    .start (start_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Saturating drop counter; the extra sum bit flags wrap-around.
  always_comb begin
    cnt_sum  = {1'b0, cnt_reg} + {{(CNT_W - IDX_W){1'b0}}, popcount(drops)};
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Output-stage next state: load a new index whenever the slot frees up.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    onehot_next  = onehot_reg;
    pending_next = pend_nx;
`ifdef REQ_PRIORITY_ENCODER_RR_EN
    ptr_next     = ptr_reg;
`endif
    if (slot_free) begin
      if (pick_found) begin
        state_next   = ST_FULL;
        idx_next     = pick_idx;
        onehot_next  = onehot(pick_idx);
        pending_next = pend_nx & ~onehot(pick_idx);
`ifdef REQ_PRIORITY_ENCODER_RR_EN
        ptr_next     = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
`endif
      end else begin
        state_next   = ST_EMPTY;
        onehot_next  = '0;
        pending_next = '0;
      end
    end
  end

  // State registers; clr_i flushes the same state as rst and wins over
  // any request or handshake in that cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      state_reg   <= ST_EMPTY;
      idx_reg     <= '0;
      onehot_reg  <= '0;
      pending_reg <= '0;
      ovf_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      onehot_reg  <= onehot_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_reg | (|drops);
      cnt_reg     <= cnt_next;
    end
  end

`ifdef REQ_PRIORITY_ENCODER_RR_EN
  // Rotation pointer: points one past the most recently loaded index.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  assign out_valid  = (state_reg == ST_FULL);
  assign out_idx    = idx_reg;
  assign out_onehot = onehot_reg;
  assign pending_o  = pending_reg;
  assign overflow_o = ovf_reg;
  assign drop_cnt_o = cnt_reg;

endmodule

// File: tb/tb_req_priority_encoder.sv
// Self-checking bench for req_priority_encoder: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a bit-array model of pending events and the output slot.
module tb_req_priority_encoder;

  localparam int NL = 8;
`ifdef REQ_PRIORITY_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] req = 8'h00;

  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending_o;
  logic       overflow_o;
  logic [7:0] drop_cnt_o;

  always #5 clk = ~clk;

  req_priority_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .clr_i      (clr),
    .out_valid  (out_valid),
    .out_ready  (ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a set of pending event numbers, one output slot, a rotation
  // start point and a capped drop tally.
  bit m_pend[NL];
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;
  bit m_ovf = 1'b0;
  int m_cnt = 0;
  int m_nd;
  int m_sel;
  bit m_stall;

  function automatic logic [7:0] model_pending();
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < NL; k++) if (m_pend[k]) v = v | (8'd1 << k);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NL; k++) m_pend[k] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
    end else begin
      m_stall = m_valid && !ready;
      m_nd = 0;
      for (int k = 0; k < NL; k++) begin
        if (req[k]) begin
          if (m_pend[k] || (m_stall && m_idx == k)) m_nd++;
          else m_pend[k] = 1'b1;
        end
      end
      if (m_nd > 0) m_ovf = 1'b1;
      m_cnt = (m_cnt + m_nd > 255) ? 255 : m_cnt + m_nd;
      if (!m_stall) begin
        m_sel = -1;
        for (int i = 0; i < NL; i++) begin
          if (m_sel < 0 && m_pend[(m_ptr + i) % NL]) m_sel = (m_ptr + i) % NL;
        end
        if (m_sel >= 0) begin
          m_valid = 1'b1;
          m_idx = m_sel;
          m_pend[m_sel] = 1'b0;
          if (RR) m_ptr = (m_sel + 1) % NL;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("out_idx", {29'd0, out_idx}, m_idx);
      check("out_onehot", {24'd0, out_onehot}, m_valid ? (32'd1 << m_idx) : 32'd0);
      check("pending_o", {24'd0, pending_o}, {24'd0, model_pending()});
      check("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
      check("drop_cnt_o", {24'd0, drop_cnt_o}, m_cnt);
    end
  end

  task automatic step(input logic [7:0] r, input logic rd, input logic c);
    @(negedge clk);
    req = r;
    ready = rd;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_onehot", {24'd0, out_onehot}, 32'd0);
    check("rst_cnt", {24'd0, drop_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, one-cycle latency
    step(8'h10, 1'b1, 1'b0);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_idx", {29'd0, out_idx}, 32'd4);
    check("t1_onehot", {24'd0, out_onehot}, 32'h10);
    step(8'h00, 1'b1, 1'b0);
    check("t1_empty", {31'd0, out_valid}, 32'd0);
    check("t1_pend", {24'd0, pending_o}, 32'd0);

    // Multi-hot, fixed order 1,2,5,7 with no bubble
    step(8'hA6, 1'b1, 1'b0);
    check("t2_idx_a", {29'd0, out_idx}, 32'd1);
    step(8'h00, 1'b1, 1'b0);
    check("t2_idx_b", {29'd0, out_idx}, RR ? 32'd2 : 32'd2);
    step(8'h00, 1'b1, 1'b0);
    check("t2_idx_c", {29'd0, out_idx}, 32'd5);
    step(8'h00, 1'b1, 1'b0);
    check("t2_idx_d", {29'd0, out_idx}, 32'd7);
    step(8'h00, 1'b1, 1'b0);
    check("t2_done", {31'd0, out_valid}, 32'd0);

    // Backpressure with drops during the stall
    step(8'h03, 1'b0, 1'b0);
    check("t3_idx", {29'd0, out_idx}, 32'd0);
    check("t3_pend", {24'd0, pending_o}, 32'h02);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0, 1'b0);
      check("t3_hold", {29'd0, out_idx}, 32'd0);
    end
    step(8'h03, 1'b0, 1'b0);
    check("t3_ovf", {31'd0, overflow_o}, 32'd1);
    check("t3_cnt", {24'd0, drop_cnt_o}, 32'd2);
    check("t3_pend2", {24'd0, pending_o}, 32'h02);
    step(8'h00, 1'b1, 1'b0);
    check("t3_rel", {29'd0, out_idx}, 32'd1);
    step(8'h00, 1'b1, 1'b0);
    check("t3_drain", {31'd0, out_valid}, 32'd0);

    // Saturation of the drop counter
    step(8'h04, 1'b0, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      step(8'h04, 1'b0, 1'b0);
      if (i == 10) check("t4_cnt10", {24'd0, drop_cnt_o}, 32'd12);
    end
    check("t4_sat", {24'd0, drop_cnt_o}, 32'hFF);
    step(8'h00, 1'b1, 1'b0);

    // clr_i beats a same-cycle request and handshake
    step(8'h01, 1'b0, 1'b0);
    step(8'hF0, 1'b0, 1'b0);
    check("t5_pend", {24'd0, pending_o}, 32'hF0);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    step(8'h01, 1'b1, 1'b1);
    check("t5_clr_valid", {31'd0, out_valid}, 32'd0);
    check("t5_clr_pend", {24'd0, pending_o}, 32'd0);
    check("t5_clr_cnt", {24'd0, drop_cnt_o}, 32'd0);
    check("t5_clr_ovf", {31'd0, overflow_o}, 32'd0);
    check("t5_clr_idx", {29'd0, out_idx}, 32'd0);

    // rst mid-transfer drops the held index
    step(8'h03, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_pend", {24'd0, pending_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All requests held high: rotation or fixed index 0
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      check("t6_idx", {29'd0, out_idx}, RR ? (i % 8) : 0);
    end
    step(8'h00, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ready = (i % 1000 < 700) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 249) == 0);
      rst   = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    req = 8'h00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
